// File: rtl/ascon_enc_loader.sv
// Ascon encryption loader: captures key, nonce, AD and plaintext words on a
// valid/ready handshake, streams them MSB-first on the core's serial inputs,
// pulses the core start line, then waits for the core's done flag.
module ascon_enc_loader #(
    parameter int K            = 128,
    parameter int Y            = 128,
    parameter int L            = 128,
    parameter int START_CYCLES = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [L-1:0] ad_i,
    input  logic [Y-1:0] pt_i,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         keyxSO,
    output logic         noncexSO,
    output logic         associated_dataxSO,
    output logic         plain_textxSO,
    output logic         encryption_startxSO,
    input  logic         encryption_readyxSI,
    output logic         busy
);

    localparam int M1 = (K > 128) ? K : 128;
    localparam int M2 = (M1 > L) ? M1 : L;
    localparam int M  = (M2 > Y) ? M2 : Y;
    localparam int CW = $clog2(M + 1);
    localparam int IW = $clog2(M);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [3:0]      start_cnt_r, start_cnt_s;
    logic            capture_s;

    logic [K-1:0]    key_r;
    logic [127:0]    nonce_r;
    logic [L-1:0]    ad_r;
    logic [Y-1:0]    pt_r;

    logic            key_so_r, nonce_so_r, ad_so_r, pt_so_r, start_so_r;
    logic            key_so_s, nonce_so_s, ad_so_s, pt_so_s, start_so_s;

    // Fields are left-aligned in an M-bit frame so that positions past a
    // short field's length land on the zero padding.
    logic [M-1:0]    key_al_s, nonce_al_s, ad_al_s, pt_al_s;
    logic [IW-1:0]   nxt_pos_s;

    assign key_al_s   = M'(key_r) << (M - K);
    assign nonce_al_s = M'(nonce_r) << (M - 128);
    assign ad_al_s    = M'(ad_r) << (M - L);
    assign pt_al_s    = M'(pt_r) << (M - Y);

    // Frame position of bit i+1 (the bit presented after the next edge).
    assign nxt_pos_s  = IW'(M - 2) - cnt_r[IW-1:0];

    // Next-state, counter and next-output decode.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        start_cnt_s = start_cnt_r;
        capture_s   = 1'b0;
        key_so_s    = 1'b0;
        nonce_so_s  = 1'b0;
        ad_so_s     = 1'b0;
        pt_so_s     = 1'b0;
        start_so_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_valid) begin
                    state_s    = ST_SHIFT;
                    cnt_s      = CW'(0);
                    capture_s  = 1'b1;
                    key_so_s   = key_i[K-1];
                    nonce_so_s = nonce_i[127];
                    ad_so_s    = ad_i[L-1];
                    pt_so_s    = pt_i[Y-1];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CW'(M - 1)) begin
                    state_s     = ST_START;
                    start_cnt_s = 4'd1;
                    start_so_s  = 1'b1;
                end else begin
                    cnt_s      = cnt_r + CW'(1);
                    key_so_s   = key_al_s[nxt_pos_s];
                    nonce_so_s = nonce_al_s[nxt_pos_s];
                    ad_so_s    = ad_al_s[nxt_pos_s];
                    pt_so_s    = pt_al_s[nxt_pos_s];
                end
            end
            ST_START: begin
                if (start_cnt_r == 4'(START_CYCLES)) begin
                    state_s = ST_WAIT;
                end else begin
                    start_cnt_s = start_cnt_r + 4'd1;
                    start_so_s  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (encryption_readyxSI) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CW'(0);
            start_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            start_cnt_r <= start_cnt_s;
        end
    end

    // Captured words; only the IDLE handshake may write them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r   <= '0;
            nonce_r <= 128'h0;
            ad_r    <= '0;
            pt_r    <= '0;
        end else if (capture_s) begin
            key_r   <= key_i;
            nonce_r <= nonce_i;
            ad_r    <= ad_i;
            pt_r    <= pt_i;
        end
    end

    // Registered serial and start outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_so_r   <= 1'b0;
            nonce_so_r <= 1'b0;
            ad_so_r    <= 1'b0;
            pt_so_r    <= 1'b0;
            start_so_r <= 1'b0;
        end else begin
            key_so_r   <= key_so_s;
            nonce_so_r <= nonce_so_s;
            ad_so_r    <= ad_so_s;
            pt_so_r    <= pt_so_s;
            start_so_r <= start_so_s;
        end
    end

    assign keyxSO              = key_so_r;
    assign noncexSO            = nonce_so_r;
    assign associated_dataxSO  = ad_so_r;
    assign plain_textxSO       = pt_so_r;
    assign encryption_startxSO = start_so_r;
    assign load_ready          = (state_r == ST_IDLE);
    assign busy                = (state_r != ST_IDLE);

endmodule

// File: tb/tb_ascon_enc_loader.sv
// Directed bench for ascon_enc_loader: default build, a short-field build
// (L=40, Y=64) and a single-cycle start build (START_CYCLES=1).
module tb_ascon_enc_loader;

    localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] N1 = 128'hF0E0D0C0B0A090807060504030201000;
    localparam logic [127:0] K2 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [127:0] K3 = 128'hA5000000000000000000000000000000;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key, nonce, ad, pt;
    logic [39:0]  ad1;
    logic [63:0]  pt1;
    logic         lv0, lv1, rdy0, rdy1, rdy2;
    logic         lr0, k0, n0, a0, p0, s0, b0;
    logic         lr1, k1, n1, a1, p1, s1, b1;
    logic         lr2, k2, n2, a2, p2, s2, b2;

    int checks = 0;
    int errors = 0;

    logic [127:0] kc, nc, ac, pc;
    logic [3:0]   ser;
    logic         saw_s;
    logic [7:0]   kb;
    int           hi;

    always #5 clk = ~clk;

    ascon_enc_loader dut0 (
        .clk(clk), .rst(rst), .key_i(key), .nonce_i(nonce), .ad_i(ad), .pt_i(pt),
        .load_valid(lv0), .load_ready(lr0), .keyxSO(k0), .noncexSO(n0),
        .associated_dataxSO(a0), .plain_textxSO(p0), .encryption_startxSO(s0),
        .encryption_readyxSI(rdy0), .busy(b0)
    );

    ascon_enc_loader #(.L(40), .Y(64)) dut1 (
        .clk(clk), .rst(rst), .key_i(key), .nonce_i(nonce), .ad_i(ad1), .pt_i(pt1),
        .load_valid(lv1), .load_ready(lr1), .keyxSO(k1), .noncexSO(n1),
        .associated_dataxSO(a1), .plain_textxSO(p1), .encryption_startxSO(s1),
        .encryption_readyxSI(rdy1), .busy(b1)
    );

    ascon_enc_loader #(.START_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .key_i(key), .nonce_i(nonce), .ad_i(ad), .pt_i(pt),
        .load_valid(lv1), .load_ready(lr2), .keyxSO(k2), .noncexSO(n2),
        .associated_dataxSO(a2), .plain_textxSO(p2), .encryption_startxSO(s2),
        .encryption_readyxSI(rdy2), .busy(b2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b0;
        lv0  = 1'b0; lv1 = 1'b0;
        rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
        key  = 128'h0; nonce = 128'h0; ad = 128'h0; pt = 128'h0;
        ad1  = 40'h0;  pt1 = 64'h0;

        // Reset held for three cycles with random inputs.
        for (int c = 0; c < 3; c++) begin
            key   = {$urandom, $urandom, $urandom, $urandom};
            nonce = {$urandom, $urandom, $urandom, $urandom};
            ad    = {$urandom, $urandom, $urandom, $urandom};
            pt    = {$urandom, $urandom, $urandom, $urandom};
            lv0   = 1'($urandom_range(0, 1));
            lv1   = 1'($urandom_range(0, 1));
            rdy0  = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_out0", 128'({k0, n0, a0, p0, s0}), 128'h0);
        chk("rst_out12", 128'({k1, n1, a1, p1, s1, k2, n2, a2, p2, s2}), 128'h0);
        chk("rst_ready_busy", 128'({lr0, b0, lr1, b1, lr2, b2}), 128'(6'b101010));

        lv0 = 1'b0; lv1 = 1'b0; rdy0 = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("idle_after_rst", 128'({lr0, b0}), 128'(2'b10));

        // Full serialization on the default build, load_valid held high.
        key = K1; nonce = N1; ad = 128'h0; pt = '1; lv0 = 1'b1;
        tick();
        key = K2; nonce = ~N1; ad = '1;
        chk("busy_after_hs", 128'({lr0, b0}), 128'(2'b01));
        saw_s = 1'b0;
        for (int i = 0; i < 128; i++) begin
            kc[127-i] = k0; nc[127-i] = n0; ac[127-i] = a0; pc[127-i] = p0;
            saw_s = saw_s | s0;
            rdy0 = (i == 60);
            tick();
        end
        rdy0 = 1'b0;
        chk("ser_key", kc, K1);
        chk("ser_nonce", nc, N1);
        chk("ser_ad", ac, 128'h0);
        chk("ser_pt", pc, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);
        chk("start_low_in_shift", 128'(saw_s), 128'h0);

        hi = 0; ser = 4'h0;
        for (int j = 0; j < 10; j++) begin
            if (j == 0) chk("start_at_e128", 128'(s0), 128'(1'b1));
            hi  = hi + int'(s0);
            ser = ser | {k0, n0, a0, p0};
            rdy0 = (j == 2);
            tick();
        end
        rdy0 = 1'b0;
        chk("start_cycles", 128'(hi), 128'(5));
        chk("ser_zero_start", 128'(ser), 128'h0);
        chk("no_early_exit", 128'({lr0, b0}), 128'(2'b01));

        for (int j = 0; j < 15; j++) tick();
        chk("still_wait", 128'(lr0), 128'h0);
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        chk("ready_after_er", 128'(lr0), 128'(1'b1));
        tick();
        chk("second_hs_busy", 128'(b0), 128'(1'b1));
        chk("second_bit0", 128'({k0, n0, a0, p0}), 128'({K2[127], nonce[127], 1'b1, 1'b1}));

        // Reset in the middle of the second transfer at bit 50.
        for (int j = 0; j < 50; j++) tick();
        chk("pre_rst_bit50", 128'({k0, p0}), 128'(2'b11));
        rst = 1'b0;
        #1;
        chk("rst_mid_out", 128'({k0, n0, a0, p0, s0}), 128'h0);
        chk("rst_mid_ready", 128'({lr0, b0}), 128'(2'b10));
        @(negedge clk);
        lv0 = 1'b0;
        rst = 1'b1;
        tick();
        chk("ready_after_release", 128'(lr0), 128'(1'b1));
        key = K3; lv0 = 1'b1;
        tick();
        lv0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            kb[7-i] = k0;
            tick();
        end
        chk("reshift_from_0", 128'(kb), 128'(8'hA5));

        // Short fields (dut1) and single-cycle start (dut2) in parallel.
        ad1 = 40'h0123456789; pt1 = 64'hDEADBEEFCAFEF00D;
        ad = 128'h0; pt = 128'h0; lv1 = 1'b1;
        tick();
        lv1 = 1'b0;
        saw_s = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ac[127-i] = a1; pc[127-i] = p1;
            saw_s = saw_s | s1 | s2;
            tick();
        end
        chk("short_ad", ac, {40'h0123456789, 88'h0});
        chk("short_pt", pc, {64'hDEADBEEFCAFEF00D, 64'h0});
        chk("short_start_low", 128'(saw_s), 128'h0);
        chk("start_e128_both", 128'({s1, s2}), 128'(2'b11));
        tick();
        chk("sc1_pulse_end", 128'({s1, s2, b2}), 128'(3'b101));
        rdy2 = 1'b1;
        tick();
        rdy2 = 1'b0;
        chk("sc1_ready", 128'(lr2), 128'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascon_enc_loader.md
# ascon_enc_loader

Upstream feeder for the Ascon AEAD encryption core. It accepts key, nonce, associated data and plaintext as parallel words through a valid/ready handshake. It shifts all four fields into the core's serial inputs MSB-first, then pulses the core's start input. It stays busy until the core reports completion, so only one encryption is in flight at a time.

## Interface
Parameters:
- K, 128, key length in bits (matches core `k`)
- Y, 128, plaintext length in bits (matches core `y`)
- L, 128, associated-data length in bits (matches core `l`)
- START_CYCLES, 5, number of cycles encryption_startxSO is held high (1..15)
- Derived M = max(K, 128, L, Y): serial shift length

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-low
- key_i  in  K  key word
- nonce_i  in  128  nonce word
- ad_i  in  L  associated-data word
- pt_i  in  Y  plaintext word
- load_valid  in  1  parallel words valid
- load_ready  out  1  loader idle, can accept words
- keyxSO  out  1  serial key bit to core
- noncexSO  out  1  serial nonce bit to core
- associated_dataxSO  out  1  serial AD bit to core
- plain_textxSO  out  1  serial plaintext bit to core
- encryption_startxSO  out  1  start request to core
- encryption_readyxSI  in  1  core done flag
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SHIFT, START, WAIT.
- IDLE:
  - load_ready=1.
  - On load_valid&load_ready at a rising edge, capture all four words into internal registers.
  - Clear bit counter i to 0, go to SHIFT.
- SHIFT: in count i (0..M-1) the serial outputs are:
  - keyxSO = key[K-1-i] if i<K, else 0
  - noncexSO = nonce[127-i] if i<128, else 0
  - associated_dataxSO = ad[L-1-i] if i<L, else 0
  - plain_textxSO = pt[Y-1-i] if i<Y, else 0
  - After i=M-1, go to START.
- START:
  - encryption_startxSO=1 for exactly START_CYCLES cycles.
  - Serial outputs are 0.
  - Then go to WAIT.
- WAIT:
  - All data outputs are 0.
  - On encryption_readyxSI=1, go to IDLE.
- encryption_readyxSI is ignored in IDLE, SHIFT and START.
- load_valid is ignored while busy; captured words never change outside the IDLE handshake.
- Counters: i is ceil(log2(M+1)) bits; the start counter is 4 bits. Neither counter wraps: each saturates by state exit.
- Asserting rst in any state:
  - forces IDLE immediately
  - clears the captured words and counters
  - drives all serial outputs and encryption_startxSO to 0 asynchronously
  - an in-progress transfer is abandoned, not resumed.

## Timing
- Reset values: load_ready=1, busy=0, keyxSO=noncexSO=associated_dataxSO=plain_textxSO=0, encryption_startxSO=0.
- All outputs are registered (no combinational input-to-output path) except load_ready/busy, which decode the state register.
- Handshake at edge E0 → first serial bit (MSBs) valid from E0 until E1. Bit i is valid between edges E(i) and E(i+1), so the core samples it on edge E(i+1).
- Last bit occupies E(M-1)..E(M). encryption_startxSO is high over edges E(M)..E(M+START_CYCLES).
- WAIT is entered at E(M+START_CYCLES).
- readyxSI sampled high at edge Er → load_ready=1 after Er. The next handshake can occur at edge Er+1.
- Minimum cycles per transfer: M+START_CYCLES+1.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs → all serial outputs and encryption_startxSO are 0, load_ready=1, busy=0. After release with load_valid=0, state stays IDLE.
- Full serialization, defaults:
  - Stimulus: key=0x000102030405060708090A0B0C0D0E0F, nonce=0xF0E0…00 pattern, ad=0x0, pt=0xFFFF…FF.
  - Required: 128 captured bits on each line match MSB-first exactly.
  - Required: encryption_startxSO high for exactly 5 cycles starting at E128, then low.
- Short field (L=40, Y=64):
  - Stimulus: ad=0x0123456789, pt=0xDEADBEEFCAFEF00D.
  - Required: associated_dataxSO emits 40 bits then 88 zeros; plain_textxSO emits 64 bits then 64 zeros; shift lasts 128 cycles.
- Busy handling:
  - Stimulus: hold load_valid=1 throughout; pulse encryption_readyxSI during SHIFT and START.
  - Required: no recapture, no early exit.
  - Stimulus: assert encryption_readyxSI 20 cycles into WAIT.
  - Required: load_ready rises on the following cycle, then the second handshake is accepted.
- Reset mid-shift: drop rst at bit 50 → outputs 0 in the same cycle, load_ready=1 after release. A new load then reshifts from bit 0.
- START_CYCLES=1: encryption_startxSO is a single-cycle pulse at E(M).
